shift_sequencer: RTL

- Controller that sequences the lab shift-counter/LED datapath from one push-button and the switch bank.
- Synchronises and debounces the raw active-low key, then issues one load pulse followed by a programmed number of timed shift pulses.
- The downstream counter, register and hex decoders consume only single-cycle load_o/shift_o strobes.
- Sits between the board inputs and the datapath at top level, in the clk100_i domain.

---
 rtl/seq_pkg.sv | 31 +++
 rtl/key_debounce.sv | 66 ++++++
 rtl/shift_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the shift sequencer and its key debouncer.
// Contents: default cycle counts, datapath widths, the sequencer FSM state
// type and a helper that sizes a counter for a given cycle count.
package seq_pkg;

    // 10 ms and 0.25 s at 100 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
    localparam int unsigned DEF_STEP_CYCLES     = 32'd25000000;

    localparam int unsigned COUNT_W = 32'd4;   // shift count N / remain
    localparam int unsigned DATA_W  = 32'd6;   // payload forwarded to data_o
    localparam int unsigned SW_W    = 32'd10;  // switch bank

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // Counter width able to hold 0..cycles-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        if (cycles < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(cycles);
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser on the inverted (active-low)
// raw key, a stability counter that only accepts a level change after the
// synchronised key has disagreed with the accepted level for DEBOUNCE_CYCLES
// consecutive cycles, and a one-cycle pulse on each accepted press.
// Ports:
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   key_i        raw key, active-low, asynchronous to clk_i
//   press_evt_o  one-cycle pulse on the debounced released->pressed edge
module key_debounce
    import seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic key_i,
    output logic press_evt_o
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic [1:0]       sync_d,  sync_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             level_d, level_q;
    logic             evt_d,   evt_q;
    logic             pressed_s;

    assign pressed_s   = sync_q[1];
    assign press_evt_o = evt_q;

    // Next-state logic for synchroniser, stability counter and press pulse.
    always_comb begin
        sync_d  = {sync_q[0], ~key_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        evt_d   = 1'b0;
        if (pressed_s == level_q) begin
            // any agreeing sample restarts the stability window
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            level_d = ~level_q;
            evt_d   = ~level_q;  // pulse only when the new level is "pressed"
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    // State registers, cleared to "released" on reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= 2'b00;
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            evt_q   <= evt_d;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for the shift-counter/LED datapath. A debounced key press
// captures the shift count N and a payload from the switches, then emits
// one load_o strobe followed by N shift_o strobes spaced STEP_CYCLES+1 apart
// and a final done_o strobe. Presses while a sequence runs are dropped.
// Both cycle-count parameters must be at least 2.
// Ports:
//   clk100_i  100 MHz clock
//   rstn_i    asynchronous active-low reset
//   key_i     raw push-button, active-low
//   sw_i      [3:0] shift count N, [9:4] payload
//   load_o    one-cycle strobe, datapath loads data_o
//   data_o    payload captured when the press was accepted
//   shift_o   one-cycle strobe, datapath shifts once
//   busy_o    high from the load_o cycle through the done_o cycle
//   done_o    one-cycle strobe after the last shift
//   remain_o  shifts still to issue
module shift_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STEP_CYCLES     = DEF_STEP_CYCLES
) (
    input  logic               clk100_i,
    input  logic               rstn_i,
    input  logic               key_i,
    input  logic [SW_W-1:0]    sw_i,
    output logic               load_o,
    output logic [DATA_W-1:0]  data_o,
    output logic               shift_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [COUNT_W-1:0] remain_o
);

    localparam int unsigned      TMR_W    = cnt_width(STEP_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 32'd1);

    logic press_evt_s;

    seq_state_e         state_d,  state_q;
    logic [COUNT_W-1:0] remain_d, remain_q;
    logic [DATA_W-1:0]  data_d,   data_q;
    logic [TMR_W-1:0]   timer_d,  timer_q;
    logic               load_d,   load_q;
    logic               shift_d,  shift_q;
    logic               done_d,   done_q;
    logic               busy_d,   busy_q;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i       (clk100_i),
        .rstn_i      (rstn_i),
        .key_i       (key_i),
        .press_evt_o (press_evt_s)
    );

    assign load_o   = load_q;
    assign shift_o  = shift_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign data_o   = data_q;
    assign remain_o = remain_q;

    // FSM next state, step timer, captured operands and strobe decode.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        data_d   = data_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                if (press_evt_s) begin
                    state_d  = LOAD;
                    remain_d = sw_i[COUNT_W-1:0];
                    data_d   = sw_i[SW_W-1:COUNT_W];
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (remain_q == {COUNT_W{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    timer_d = {TMR_W{1'b0}};
                end
            end
            WAIT: begin
                if (timer_q == TMR_LAST) begin
                    state_d = SHIFT;
                end else begin
                    timer_d = timer_q + TMR_W'(1'b1);
                end
            end
            SHIFT: begin
                // remain_o shows the pre-shift count during the shift cycle
                remain_d = remain_q - COUNT_W'(1'b1);
                if (remain_q == COUNT_W'(1'b1)) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    timer_d = {TMR_W{1'b0}};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                remain_d = {COUNT_W{1'b0}};
                timer_d  = {TMR_W{1'b0}};
            end
        endcase

        // strobes are decoded from the next state so they leave a flop
        load_d  = (state_d == LOAD);
        shift_d = (state_d == SHIFT);
        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // FSM, timer, operand and output registers.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            remain_q <= {COUNT_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            timer_q  <= {TMR_W{1'b0}};
            load_q   <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            timer_q  <= timer_d;
            load_q   <= load_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

endmodule
